// File: rtl/mem_arbiter.sv
// Two-port (fetch I / load-store D) arbiter in front of one single-ported synchronous word RAM.
// Optional stall counters are enabled by defining MEMARB_PERF_EN.
module mem_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]       perf_i_stall,
    output logic [31:0]       perf_d_stall
`endif
);

    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_e     owner_q, owner_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       forced;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    assign forced = i_req && (starve_cnt_q == LIMIT);

    always_comb begin
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        m_addr       = '0;
        owner_d      = OWN_NONE;
        starve_cnt_d = starve_cnt_q;
        // Grants are suppressed during reset so no access reaches the RAM.
        if (!reset) begin
            if (forced)     i_gnt = 1'b1;
            else if (d_req) d_gnt = 1'b1;
            else if (i_req) i_gnt = 1'b1;
        end
        if (i_gnt)      m_addr = i_addr[ADDR_W+1:2];
        else if (d_gnt) m_addr = d_addr[ADDR_W+1:2];
        if (i_gnt)              owner_d = OWN_I;
        else if (d_gnt && !d_we) owner_d = OWN_D;
        if (!i_req || i_gnt)           starve_cnt_d = '0;
        else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
    end

    assign m_en    = i_gnt | d_gnt;
    assign m_we    = d_gnt & d_we;
    assign m_wdata = d_wdata;

    // Gating with reset kills the return of a read granted just before reset rose.
    assign i_rvalid = (owner_q == OWN_I) && !reset;
    assign d_rvalid = (owner_q == OWN_D) && !reset;
    assign i_rdata  = i_rvalid ? m_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? m_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef MEMARB_PERF_EN
    logic [31:0] perf_i_q, perf_i_d, perf_d_q, perf_d_d;

    always_comb begin
        perf_i_d = perf_i_q;
        perf_d_d = perf_d_q;
        if (i_req && !i_gnt && perf_i_q != 32'hFFFF_FFFF) perf_i_d = perf_i_q + 32'd1;
        if (d_req && !d_gnt && perf_d_q != 32'hFFFF_FFFF) perf_d_d = perf_d_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
        end else begin
            perf_i_q <= perf_i_d;
            perf_d_q <= perf_d_d;
        end
    end

    assign perf_i_stall = perf_i_q;
    assign perf_d_stall = perf_d_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported synchronous word RAM between two requesters: instruction fetch (port I) and load/store (port D).
- Used when imem/dmem are merged into a unified memory for the multicycle/pipelined SimpleARM core.
- Fixed priority to D, with a starvation guard that forces an I grant after a bounded number of consecutive denials.
- Routes the one-cycle-latency read data back to whichever requester owned the access.

Parameters:
- ADDR_W, 7, word-address width of the RAM (128 words).
- STARVE_LIMIT, 3, consecutive cycles I may be denied while requesting before I is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, level, held until granted
- i_addr  in  32  fetch byte address; bits [1:0] ignored
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid (registered, cycle after i_gnt)
- i_rdata  out  32  fetch data
- d_req  in  1  load/store request, level
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  byte address; bits [1:0] ignored
- d_wdata  in  32  store data
- d_gnt  out  1  load/store accepted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered, cycle after d_gnt with d_we=0)
- d_rdata  out  32  load data
- m_en  out  1  RAM access enable
- m_we  out  1  RAM write enable
- m_addr  out  ADDR_W  RAM word address = addr[ADDR_W+1:2]
- m_wdata  out  32  RAM write data
- m_rdata  in  32  RAM read data, valid the cycle after m_en with m_we=0

Behaviour:
- Reset:
  - i_rvalid = d_rvalid = 0.
  - Owner register = NONE.
  - Starvation counter = 0.
  - All registered outputs cleared.
  - While reset is high, i_gnt, d_gnt, m_en and m_we are forced to 0.
  - A read issued in the cycle before reset asserts produces no rvalid.
- Arbitration, evaluated combinationally each cycle:
  - Forced = i_req && starve_cnt == STARVE_LIMIT.
  - If forced: grant I.
  - Else if d_req: grant D.
  - Else if i_req: grant I.
  - Else: no grant.
  - At most one of i_gnt/d_gnt is high in any cycle.
- Memory drive:
  - m_en = i_gnt | d_gnt.
  - m_we = d_gnt & d_we.
  - m_addr and m_wdata come from the winner; m_wdata = d_wdata, don't-care when I wins.
  - When idle, m_addr is held at 0.
- Owner register, next state:
  - I if i_gnt.
  - D if d_gnt && !d_we.
  - Else NONE.
- Read return latency is 1:
  - i_rvalid = (owner == I); d_rvalid = (owner == D).
  - i_rdata/d_rdata = m_rdata when the matching rvalid is high, else 0.
  - Stores never produce d_rvalid.
- Starvation counter:
  - Increments when i_req && !i_gnt.
  - Clears to 0 on i_gnt or when i_req is low.
  - Saturates at STARVE_LIMIT.
- Requesters must hold their request and payload stable until granted. Deasserting a request before grant is legal; the request is simply withdrawn.
- Back-to-back: a new grant may issue every cycle. Read-after-write to the same address in consecutive cycles returns the new data, which relies on RAM write-first/registered-read order.
- No internal buffering. The arbiter never stalls the RAM; the requester stalls via low gnt.

Optional Feature:
- Macro: MEMARB_PERF_EN.
- Defined: adds outputs perf_i_stall [31:0] and perf_d_stall [31:0].
  - perf_i_stall increments each cycle i_req && !i_gnt.
  - perf_d_stall increments each cycle d_req && !d_gnt.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-read:
  - Stimulus: i_req=1, i_addr=0x10 granted at cycle N; reset=1 at N+1.
  - Response: i_rvalid=0 at N+1; all gnt=0 while reset is high.
- Single fetch:
  - Stimulus: RAM[4]=32'hE1A03400; i_req=1, i_addr=0x10.
  - Response: i_gnt=1, m_addr=4, m_we=0 same cycle; next cycle i_rvalid=1, i_rdata=32'hE1A03400.
- Store then load:
  - Stimulus: d_req=1, d_we=1, d_addr=0xFC, d_wdata=0x5 (m_addr=63, m_we=1); next cycle d_we=0, same address.
  - Response: no d_rvalid after the store; the cycle after the load, d_rvalid=1, d_rdata=0x5.
- Contention:
  - Stimulus: i_req and d_req both held high for 6 cycles, STARVE_LIMIT=3.
  - Response, grant sequence: D,D,D,I,D,D. The counter reads 3 in cycle 4 and resets after the I grant.
- Withdrawn request:
  - Stimulus: i_req high 1 cycle while d_req wins, then i_req drops.
  - Response: i_gnt never asserted; starve_cnt returns to 0.
- Perf counters (MEMARB_PERF_EN defined):
  - Stimulus: the contention scenario above.
  - Response: perf_i_stall=5, perf_d_stall=1 after the 6 cycles.
